ifetch_queue: RTL and testbench

Instruction-fetch queue sitting directly downstream of the program counter register: accepts each fetch address from the PC stage, issues it to instruction memory over a valid/ready request channel, pairs in-order responses with their PCs and presents `{pc, instruction}` to decode. Hides variable memory latency behind a DEPTH-entry circular buffer and discards in-flight fetches on a branch/jump redirect (flush).

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_slot_buf.sv | 116 +++++++++++
 rtl/ifetch_queue.sv | 84 ++++++++
 tb/tb_ifetch_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// The optional feature is enabled with the macro IFETCH_MISALIGN_TRAP_EN (see ifetch_queue).
package ifetch_pkg;

   localparam int unsigned IFQ_DEPTH    = 4;
   localparam int unsigned IFQ_XLEN     = 32;
   localparam logic [31:0] IFQ_NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [IFQ_XLEN-1:0] pc;
      logic [IFQ_XLEN-1:0] data;
      logic                done;
      logic                kill;
      logic                fault;
   } entry_t;

   // Pointer width for a DEPTH-entry ring (at least one bit).
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ifetch_slot_buf.sv
// DEPTH-entry circular entry store with alloc/fill/head pointers, response pairing and flush kill marking.
module ifetch_slot_buf
   import ifetch_pkg::*;
#(
   parameter int unsigned DEPTH = IFQ_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alloc_en,
   input  entry_t                  alloc_entry,
   input  logic                    rsp_valid,
   input  logic [IFQ_XLEN-1:0]     rsp_data,
   input  logic                    pop_en,
   input  logic                    flush,
   output entry_t                  head_entry,
   output logic                    head_alloc,
   output logic [ptr_w(DEPTH):0]   count
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = PW + 1;

   entry_t          slots_q [DEPTH];
   entry_t          slots_d [DEPTH];
   logic [PW-1:0]   alloc_q, alloc_d;
   logic [PW-1:0]   fill_q,  fill_d;
   logic [PW-1:0]   head_q,  head_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   pend_q,  pend_d;
   logic [CW-1:0]   pend_rem;
   logic [PW-1:0]   next_wait;
   logic [PW-1:0]   idx;
   logic            stop;
   logic            rsp_en;
   logic            alloc_await;

   assign rsp_en      = rsp_valid && (pend_q != '0);
   assign alloc_await = alloc_en && !alloc_entry.done;
   assign pend_rem    = pend_q - CW'(rsp_en);

   // Oldest entry still waiting for memory after the current fill target.
   always_comb begin
      next_wait = fill_q;
      stop      = 1'b0;
      idx       = fill_q;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         idx = fill_q + PW'(k);
         if (!stop) begin
            if (idx == alloc_q) begin
               stop = 1'b1;
            end else if (!slots_q[idx].done) begin
               next_wait = idx;
               stop      = 1'b1;
            end
         end
      end
   end

   always_comb begin
      slots_d = slots_q;
      alloc_d = alloc_q;
      fill_d  = fill_q;
      head_d  = head_q;
      count_d = count_q + CW'(alloc_en) - CW'(pop_en);
      pend_d  = pend_q + CW'(alloc_await) - CW'(rsp_en);

      if (rsp_en) begin
         slots_d[fill_q].data = rsp_data;
         slots_d[fill_q].done = 1'b1;
      end
      // Free slots get kill cleared when reallocated, so marking every slot is safe.
      if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            slots_d[i].kill = 1'b1;
         end
      end
      if (alloc_en) begin
         slots_d[alloc_q] = alloc_entry;
         alloc_d          = alloc_q + PW'(1);
      end
      if (pop_en) begin
         head_d = head_q + PW'(1);
      end
      // With nothing left outstanding, fill parks on the next entry that will need memory.
      if (pend_rem != '0) begin
         fill_d = rsp_en ? next_wait : fill_q;
      end else begin
         fill_d = alloc_await ? alloc_q : alloc_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            slots_q[i] <= '0;
         end
         alloc_q <= '0;
         fill_q  <= '0;
         head_q  <= '0;
         count_q <= '0;
         pend_q  <= '0;
      end else begin
         slots_q <= slots_d;
         alloc_q <= alloc_d;
         fill_q  <= fill_d;
         head_q  <= head_d;
         count_q <= count_d;
         pend_q  <= pend_d;
      end
   end

   assign head_entry = slots_q[head_q];
   assign head_alloc = (count_q != '0);
   assign count      = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: PC handshake, memory request credit and decode presentation.
// Define IFETCH_MISALIGN_TRAP_EN to trap misaligned fetch PCs locally instead of requesting them.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int unsigned DEPTH    = IFQ_DEPTH,
   parameter logic [31:0] NOP_INST = IFQ_NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   input  logic        flush,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   input  logic        inst_ready
);

   localparam int unsigned CW = ptr_w(DEPTH) + 1;

   entry_t          alloc_entry;
   entry_t          head;
   logic            head_alloc;
   logic [CW-1:0]   count;
   logic            credit;
   logic            misaligned;
   logic            accept;
   logic            head_live;
   logic            pop;

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign misaligned = (pc_in[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Killed entries keep their credit until their response retires them.
   assign credit         = (count < CW'(DEPTH));
   assign imem_req_valid = pc_valid && credit && !flush && !misaligned;
   assign imem_req_addr  = {pc_in[31:2], 2'b00};
   assign pc_ready       = credit && !flush && (imem_req_ready || misaligned);
   assign accept         = pc_valid && pc_ready;

   always_comb begin
      alloc_entry       = '0;
      alloc_entry.pc    = pc_in;
      alloc_entry.data  = misaligned ? NOP_INST : '0;
      alloc_entry.done  = misaligned;
      alloc_entry.fault = misaligned;
   end

   assign head_live  = head_alloc && head.done;
   assign inst_valid = head_live && !head.kill && !flush;
   assign inst_data  = inst_valid ? head.data  : NOP_INST;
   assign inst_pc    = inst_valid ? head.pc    : '0;
   assign inst_fault = inst_valid && head.fault;
   // Completed killed heads drain silently; nothing retires during a flush cycle.
   assign pop        = !flush && head_live && (head.kill || inst_ready);

   ifetch_slot_buf #(
      .DEPTH (DEPTH)
   ) u_slot_buf (
      .clk         (clk),
      .rst         (rst),
      .alloc_en    (accept),
      .alloc_entry (alloc_entry),
      .rsp_valid   (imem_rsp_valid),
      .rsp_data    (imem_rsp_data),
      .pop_en      (pop),
      .flush       (flush),
      .head_entry  (head),
      .head_alloc  (head_alloc),
      .count       (count)
   );

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized traffic vs. a queue-level model.
module tb_ifetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFETCH_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk, rst;
   logic [31:0] pc_in;
   logic        pc_valid, pc_ready, flush;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic        inst_valid, inst_fault, inst_ready;
   logic [31:0] inst_data, inst_pc;

   ifetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_data(inst_data),
      .inst_pc(inst_pc), .inst_fault(inst_fault), .inst_ready(inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      bit          done;
      bit          kill;
      bit          fault;
   } ment_t;
   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   ment_t       mq[$];
   req_t        rq[$];
   logic [31:0] seen_pc[$];
   logic [31:0] seen_data[$];
   bit          seen_fault[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          lat_min = 1, lat_max = 1;
   int          acc_cnt = 0;
   bit          acc;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (addr == 32'h40) return 32'h13;
      return {2'b00, addr[31:2]} + 32'hA;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive at negedge, compare against the model, then advance the model at posedge.
   task automatic step(input bit pv, input logic [31:0] pc, input bit rdy, input bit fl, input bit rqr);
      bit          credit, mis, e_ready, e_rv, hv, pop, found;
      logic [31:0] e_data, e_pc;
      pc_valid = pv; pc_in = pc; inst_ready = rdy; flush = fl; imem_req_ready = rqr;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(rq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #1;
      credit  = mq.size() < DEPTH;
      mis     = TRAP && (pc[1:0] != 2'b00);
      e_ready = credit && !fl && (rqr || mis);
      e_rv    = pv && credit && !fl && !mis;
      hv      = mq.size() > 0 && mq[0].done && !mq[0].kill && !fl;
      e_data  = hv ? mq[0].data : NOP;
      e_pc    = hv ? mq[0].pc : 32'h0;
      chk("pc_ready", 32'(pc_ready), 32'(e_ready));
      chk("imem_req_valid", 32'(imem_req_valid), 32'(e_rv));
      if (e_rv) chk("imem_req_addr", imem_req_addr, {pc[31:2], 2'b00});
      chk("inst_valid", 32'(inst_valid), 32'(hv));
      chk("inst_data", inst_data, e_data);
      chk("inst_pc", inst_pc, e_pc);
      chk("inst_fault", 32'(inst_fault), 32'(hv && mq[0].fault));

      pop = !fl && mq.size() > 0 && mq[0].done && (mq[0].kill || rdy);
      if (hv && rdy) begin
         seen_pc.push_back(mq[0].pc);
         seen_data.push_back(mq[0].data);
         seen_fault.push_back(mq[0].fault);
      end
      if (imem_rsp_valid) begin
         found = 1'b0;
         foreach (mq[i]) begin
            if (!found && !mq[i].done) begin
               mq[i].data = imem_rsp_data;
               mq[i].done = 1'b1;
               found      = 1'b1;
            end
         end
         void'(rq.pop_front());
      end
      if (fl) foreach (mq[i]) mq[i].kill = 1'b1;
      if (pop) void'(mq.pop_front());
      acc = pv && e_ready;
      if (acc) begin
         mq.push_back('{pc: pc, data: mis ? NOP : 32'h0, done: mis, kill: 1'b0, fault: mis});
         acc_cnt++;
      end
      if (e_rv && rqr) rq.push_back('{addr: {pc[31:2], 2'b00},
                                      due: cyc + $urandom_range(lat_max, lat_min)});
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic drain();
      int budget = 200;
      while ((mq.size() > 0 || rq.size() > 0) && budget > 0) begin
         idle(1);
         budget--;
      end
      chk("drain_timeout", 32'(budget == 0), 32'h0);
   endtask

   task automatic clear_seen();
      seen_pc.delete(); seen_data.delete(); seen_fault.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0; pc_valid = 1'b0; flush = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
      #1;
      chk("rst_inst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst_data", inst_data, NOP);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_inst_fault", 32'(inst_fault), 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_pc_ready", 32'(pc_ready), 32'h1);
      mq.delete();
      @(posedge clk); cyc++; @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] pc;
      int          guard;
      rst = 1'b0; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      @(negedge clk);
      do_reset();

      // In-order delivery with single-cycle memory.
      lat_min = 1; lat_max = 1;
      step(1, 32'h0, 1, 0, 1);
      step(1, 32'h4, 1, 0, 1);
      step(1, 32'h8, 1, 0, 1);
      idle(4);
      chk("t1_count", 32'(seen_pc.size()), 32'd3);
      if (seen_pc.size() == 3) begin
         chk("t1_pc0", seen_pc[0], 32'h0); chk("t1_d0", seen_data[0], 32'hA);
         chk("t1_pc1", seen_pc[1], 32'h4); chk("t1_d1", seen_data[1], 32'hB);
         chk("t1_pc2", seen_pc[2], 32'h8); chk("t1_d2", seen_data[2], 32'hC);
      end
      clear_seen();

      // Five-cycle memory: credit runs out after DEPTH accepts.
      lat_min = 5; lat_max = 5; acc_cnt = 0; pc = 32'h100;
      for (int i = 0; i < 6; i++) begin
         step(1, pc, 1, 0, 1);
         if (acc) pc += 4;
      end
      chk("t2_accepts", 32'(acc_cnt), 32'd4);
      for (int i = 0; i < 10; i++) begin
         step(1, pc, 1, 0, 1);
         if (acc) pc += 4;
      end
      drain();
      clear_seen();

      // Flush kills two outstanding fetches; only the redirect target is decoded.
      lat_min = 3; lat_max = 3;
      step(1, 32'h10, 1, 0, 1);
      step(1, 32'h14, 1, 0, 1);
      step(0, 32'h0, 1, 1, 1);
      idle(4);
      guard = 0;
      do begin
         step(1, 32'h40, 1, 0, 1);
         guard++;
      end while (!acc && guard < 10);
      idle(5);
      chk("t3_count", 32'(seen_pc.size()), 32'd1);
      if (seen_pc.size() == 1) begin
         chk("t3_pc", seen_pc[0], 32'h40);
         chk("t3_data", seen_data[0], 32'h13);
      end
      clear_seen();

      // Decode stalled: queue fills and holds the oldest entry.
      lat_min = 1; lat_max = 1; pc = 32'h0;
      for (int i = 0; i < 7; i++) begin
         step(1, pc, 0, 0, 1);
         if (acc) pc += 4;
      end
      #1;
      chk("t4_pc_ready", 32'(pc_ready), 32'h0);
      chk("t4_inst_valid", 32'(inst_valid), 32'h1);
      chk("t4_inst_pc", inst_pc, 32'h0);
      drain();
      clear_seen();

`ifdef IFETCH_MISALIGN_TRAP_EN
      // Misaligned PC traps locally and stays in program order.
      step(1, 32'h1C, 1, 0, 1);
      step(1, 32'h22, 1, 0, 1);
      step(1, 32'h24, 1, 0, 1);
      idle(4);
      chk("t5_count", 32'(seen_pc.size()), 32'd3);
      if (seen_pc.size() == 3) begin
         chk("t5_pc0", seen_pc[0], 32'h1C);
         chk("t5_pc1", seen_pc[1], 32'h22);
         chk("t5_f1", 32'(seen_fault[1]), 32'h1);
         chk("t5_d1", seen_data[1], NOP);
         chk("t5_pc2", seen_pc[2], 32'h24);
         chk("t5_f2", 32'(seen_fault[2]), 32'h0);
      end
      clear_seen();
`endif

      // Reset with fetches in flight; late responses must be ignored.
      lat_min = 6; lat_max = 6;
      step(1, 32'h200, 1, 0, 1);
      step(1, 32'h204, 1, 0, 1);
      idle(1);
      do_reset();
      for (int i = 0; i < 8; i++) step(0, 32'h0, 1, 0, 1);
      chk("t6_rq_empty", 32'(rq.size()), 32'h0);
      chk("t6_seen", 32'(seen_pc.size()), 32'h0);

      // Randomized traffic.
      lat_min = 1; lat_max = 6;
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(9, 0) < 7), $urandom, 1'($urandom_range(1, 0)),
              1'($urandom_range(99, 0) < 3), 1'($urandom_range(9, 0) < 8));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
